data_memory_dump_unit: RTL and testbench
========================================

Name: data_memory_dump_unit

Overview:
- Parametrised, synchronous data memory for the pipelined datapath, with lane-masked writes and a registered read.
- Adds a hardware sweep engine that runs through the whole array in one of two modes:
  - dump mode: streams every word out over a valid/ready port, so simulation and FPGA runs can export memory without hierarchical access;
  - clear mode: zero-fills the array.
- Sits in the MEM stage and replaces the plain data memory instance. While a sweep runs, it raises a busy flag that feeds the hazard unit's stall.

Parameters:
- DATA_WIDTH, 20, word width in bits.
- ADDRESS_WIDTH, 8, word-address width.
- MEM_SIZE, 256, number of words; must be <= 2**ADDRESS_WIDTH.
- LANE_WIDTH, 10, bits per write lane; DATA_WIDTH must be divisible by LANE_WIDTH.
- LANES, DATA_WIDTH/LANE_WIDTH, derived number of lanes; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  ADDRESS_WIDTH  pipeline word address.
- mem_write_data  in  DATA_WIDTH  pipeline store data.
- MemRead  in  1  pipeline load request.
- MemWrite  in  1  pipeline store request.
- lane_mask  in  LANES  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH].
- mem_read_data  out  DATA_WIDTH  load data, registered.
- mem_busy  out  1  sweep in progress; pipeline must stall.
- sweep_start  in  1  single-cycle request to begin a sweep.
- sweep_mode  in  1  0 = dump, 1 = clear; sampled with sweep_start.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word.
- dump_addr  out  ADDRESS_WIDTH  address of the presented dump word.
- dump_data  out  DATA_WIDTH  presented dump word.
- sweep_done  out  1  single-cycle pulse when a sweep completes.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - mem_read_data, dump_valid, dump_addr, dump_data, sweep_done and mem_busy go to 0.
  - Sweep counter goes to 0.
  - Array contents are not reset.
- Pipeline write (not busy, MemWrite=1, mem_addr < MEM_SIZE):
  - lanes with lane_mask=1 are written at the clock edge;
  - other lanes keep their value.
- Pipeline read (not busy, MemRead=1):
  - mem_read_data = mem[mem_addr] one cycle later;
  - otherwise mem_read_data holds its value.
  - Read and write to the same address in the same cycle return the OLD word (read-before-write).
- Out-of-range address (mem_addr >= MEM_SIZE): write ignored, read returns 0.
- Busy gating: while mem_busy=1, MemRead, MemWrite and mem_addr are ignored entirely.
- FSM states: IDLE, RD, SEND, CLR, DONE.
  - IDLE:
    - sweep_start=1: counter<=0, mem_busy<=1, go to RD if sweep_mode=0, CLR if 1.
    - A pipeline access in the same cycle as sweep_start still completes, then the sweep starts.
  - RD: fetch mem[counter] into dump_data, dump_addr<=counter, dump_valid<=1, go to SEND.
  - SEND:
    - Hold dump_valid, dump_addr and dump_data stable until dump_ready=1 (the handshake fires on valid&&ready).
    - On handshake: dump_valid<=0. If counter == MEM_SIZE-1, go to DONE; else counter+1 and go to RD.
    - Throughput is one word per 2 cycles at best.
  - CLR: write 0 to mem[counter] (all lanes), one word per cycle. At MEM_SIZE-1 go to DONE, else counter+1.
  - DONE: sweep_done=1 for exactly one cycle, mem_busy<=0, go to IDLE. The pipeline may access memory on the next cycle.
- sweep_start while not in IDLE is ignored; a sweep is never restarted or queued.
- Sweep counter is ADDRESS_WIDTH+1 bits wide, so MEM_SIZE = 2**ADDRESS_WIDTH terminates without wrap-around.
- Asynchronous reset mid-sweep aborts immediately: no sweep_done pulse, and a partially cleared array stays partially cleared.
- Total latency, sweep_start to sweep_done:
  - clear mode: MEM_SIZE+2 cycles;
  - dump mode with dump_ready tied high: 2*MEM_SIZE+2 cycles.

Decomposition:
- Shared package datapath_pkg:
  - sweep_state_t enum (IDLE, RD, SEND, CLR, DONE);
  - SWEEP_DUMP/SWEEP_CLEAR mode constants;
  - default DATA_WIDTH, ADDRESS_WIDTH and MEM_SIZE constants shared with datapath_unit.
- One sub-module, lane_masked_ram: array, lane-masked write, registered read, range check. The FSM and muxing stay in the top.

Test Plan:
- Lane-masked write: write 0xABCDE with lane_mask=2'b11 to addr 5, then 0x00012 with lane_mask=2'b01 -> read of addr 5 returns 0xABC12 one cycle after MemRead.
- Read-before-write: same-cycle read and write of addr 7 (old 0x11111, new 0x22222) -> read data 0x11111, next read 0x22222.
- Out of range: MEM_SIZE=200, write addr 220 -> no array change, read of addr 220 returns 0.
- Dump with backpressure: preload mem[i]=i, start a dump, dump_ready toggling every 3 cycles -> exactly 256 handshakes, dump_addr 0..255 in order with data == addr, words held stable while not ready, one sweep_done pulse, mem_busy low afterwards.
- Clear plus busy gating: start a clear, issue MemWrite of 0x3FFFF to addr 3 at cycle 10 -> write ignored, sweep_done at cycle 258, every word reads 0.
- Reset mid-dump: rst at the 40th handshake -> dump_valid and mem_busy drop asynchronously, no sweep_done pulse, a new sweep starts cleanly from addr 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and default geometry for the pipelined datapath's MEM stage.
// Also holds the sweep engine state encoding.
package datapath_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 20;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;
    localparam int DEFAULT_MEM_SIZE      = 256;

    localparam logic SWEEP_DUMP  = 1'b0;
    localparam logic SWEEP_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        SEND = 3'd2,
        CLR  = 3'd3,
        DONE = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/lane_masked_ram.sv
// Word-addressed array with lane-masked write and two registered read ports.
// The pipeline read port is range-checked; the sweep read port always addresses valid words.
module lane_masked_ram #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int LANE_WIDTH    = 10,
    localparam int LANES        = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [LANES-1:0]         wr_mask,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     sweep_rd_en,
    input  logic [ADDRESS_WIDTH-1:0] sweep_rd_addr,
    output logic [DATA_WIDTH-1:0]    sweep_rd_data
);

    localparam logic [ADDRESS_WIDTH:0] SIZE_W = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  wr_in_range_s;
    logic                  rd_in_range_s;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] sweep_rd_data_d;
    logic [DATA_WIDTH-1:0] sweep_rd_data_q;

    assign wr_in_range_s = ({1'b0, wr_addr} < SIZE_W);
    assign rd_in_range_s = ({1'b0, rd_addr} < SIZE_W);

    // Array update: only enabled lanes change; the contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Read-port next values; reads see the pre-write word of the same cycle.
    always_comb begin
        rd_data_d       = rd_data_q;
        sweep_rd_data_d = sweep_rd_data_q;
        if (rd_en) begin
            if (rd_in_range_s) begin
                rd_data_d = mem[rd_addr];
            end else begin
                rd_data_d = {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_data_d = rd_data_q;
        end
        if (sweep_rd_en) begin
            sweep_rd_data_d = mem[sweep_rd_addr];
        end else begin
            sweep_rd_data_d = sweep_rd_data_q;
        end
    end

    // Read data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q       <= {DATA_WIDTH{1'b0}};
            sweep_rd_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_data_q       <= rd_data_d;
            sweep_rd_data_q <= sweep_rd_data_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign sweep_rd_data = sweep_rd_data_q;

endmodule

// File: rtl/data_memory_dump_unit.sv
// MEM-stage data memory with a sweep engine that either streams every word out
// over a valid/ready port (dump) or zero-fills the array (clear), stalling the pipeline meanwhile.
module data_memory_dump_unit
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int MEM_SIZE      = DEFAULT_MEM_SIZE,
    parameter int LANE_WIDTH    = 10,
    localparam int LANES        = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [LANES-1:0]         lane_mask,
    output logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     mem_busy,
    input  logic                     sweep_start,
    input  logic                     sweep_mode,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDRESS_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0]    dump_data,
    output logic                     sweep_done
);

    // One extra counter bit keeps MEM_SIZE == 2**ADDRESS_WIDTH from wrapping.
    localparam logic [ADDRESS_WIDTH:0] LAST_W = (ADDRESS_WIDTH + 1)'(MEM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH:0] ONE_W  = (ADDRESS_WIDTH + 1)'(1);

    sweep_state_t             state_d, state_q;
    logic [ADDRESS_WIDTH:0]   count_d, count_q;
    logic                     mem_busy_d, mem_busy_q;
    logic                     dump_valid_d, dump_valid_q;
    logic [ADDRESS_WIDTH-1:0] dump_addr_d, dump_addr_q;
    logic                     sweep_done_d, sweep_done_q;

    logic                     sweep_rd_en_s;
    logic                     clr_en_s;
    logic                     wr_en_s;
    logic [ADDRESS_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0]    wr_data_s;
    logic [LANES-1:0]         wr_mask_s;
    logic                     rd_en_s;

    // Sweep FSM next-state and output logic.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        mem_busy_d    = mem_busy_q;
        dump_valid_d  = dump_valid_q;
        dump_addr_d   = dump_addr_q;
        sweep_done_d  = 1'b0;
        sweep_rd_en_s = 1'b0;
        clr_en_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    count_d    = {(ADDRESS_WIDTH + 1){1'b0}};
                    mem_busy_d = 1'b1;
                    if (sweep_mode == SWEEP_DUMP) begin
                        state_d = RD;
                    end else begin
                        state_d = CLR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                sweep_rd_en_s = 1'b1;
                dump_addr_d   = count_q[ADDRESS_WIDTH-1:0];
                dump_valid_d  = 1'b1;
                state_d       = SEND;
            end
            SEND: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (count_q == LAST_W) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + ONE_W;
                        state_d = RD;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            CLR: begin
                clr_en_s = 1'b1;
                if (count_q == LAST_W) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + ONE_W;
                    state_d = CLR;
                end
            end
            DONE: begin
                sweep_done_d = 1'b1;
                mem_busy_d   = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mem_busy_d   = 1'b0;
                dump_valid_d = 1'b0;
            end
        endcase
    end

    // Array port steering: the clear engine owns the write port, otherwise the unstalled pipeline.
    always_comb begin
        if (clr_en_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = count_q[ADDRESS_WIDTH-1:0];
            wr_data_s = {DATA_WIDTH{1'b0}};
            wr_mask_s = {LANES{1'b1}};
        end else begin
            wr_en_s   = MemWrite && !mem_busy_q;
            wr_addr_s = mem_addr;
            wr_data_s = mem_write_data;
            wr_mask_s = lane_mask;
        end
        rd_en_s = MemRead && !mem_busy_q;
    end

    // FSM and sweep output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= {(ADDRESS_WIDTH + 1){1'b0}};
            mem_busy_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= {ADDRESS_WIDTH{1'b0}};
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mem_busy_q   <= mem_busy_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    lane_masked_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .MEM_SIZE     (MEM_SIZE),
        .LANE_WIDTH   (LANE_WIDTH)
    ) u_ram (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en_s),
        .wr_addr      (wr_addr_s),
        .wr_data      (wr_data_s),
        .wr_mask      (wr_mask_s),
        .rd_en        (rd_en_s),
        .rd_addr      (mem_addr),
        .rd_data      (mem_read_data),
        .sweep_rd_en  (sweep_rd_en_s),
        .sweep_rd_addr(count_q[ADDRESS_WIDTH-1:0]),
        .sweep_rd_data(dump_data)
    );

    assign mem_busy   = mem_busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_data_memory_dump_unit.sv
// Scoreboard bench for data_memory_dump_unit: a 256-word main instance plus a
// 200-word instance for out-of-range behaviour.
module tb_data_memory_dump_unit;
    import datapath_pkg::*;

    localparam int DW = 20;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_write_data = '0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic [1:0]    lane_mask = 2'b00;
    logic          sweep_start = 1'b0;
    logic          sweep_mode = 1'b0;
    logic          dump_ready = 1'b1;
    logic          small_sweep_start = 1'b0;

    logic [DW-1:0] mem_read_data, dump_data;
    logic [AW-1:0] dump_addr;
    logic          mem_busy, dump_valid, sweep_done;
    logic [DW-1:0] s_mem_read_data, s_dump_data;
    logic [AW-1:0] s_dump_addr;
    logic          s_mem_busy, s_dump_valid, s_sweep_done;

    data_memory_dump_unit dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .lane_mask(lane_mask),
        .mem_read_data(mem_read_data), .mem_busy(mem_busy),
        .sweep_start(sweep_start), .sweep_mode(sweep_mode),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .sweep_done(sweep_done)
    );

    data_memory_dump_unit #(.MEM_SIZE(200)) dut_small (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .lane_mask(lane_mask),
        .mem_read_data(s_mem_read_data), .mem_busy(s_mem_busy),
        .sweep_start(small_sweep_start), .sweep_mode(sweep_mode),
        .dump_valid(s_dump_valid), .dump_ready(dump_ready), .dump_addr(s_dump_addr),
        .dump_data(s_dump_data), .sweep_done(s_sweep_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- pipeline read scoreboard ----------------
    typedef struct {
        logic [DW-1:0] exp;
        logic          chk_small;
        logic [DW-1:0] exp_small;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    logic          rd_issue  = 1'b0;
    logic          rd_strobe = 1'b0;
    logic [DW-1:0] last_rd_exp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_strobe <= 1'b0;
        else     rd_strobe <= rd_issue;
    end

    always @(negedge clk) begin : rd_monitor
        rd_exp_t e;
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got read data 0x%0h, expected no read", mem_read_data);
            end else begin
                e = rd_q.pop_front();
                check("rd_data", 32'(mem_read_data), 32'(e.exp));
                if (e.chk_small) check("rd_data_small", 32'(s_mem_read_data), 32'(e.exp_small));
                last_rd_exp = e.exp;
            end
        end
    end

    // ---------------- dump scoreboard ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } dump_exp_t;

    dump_exp_t     dump_q[$];
    int            hs_count   = 0;
    int            done_count = 0;
    int            done_cyc   = 0;
    logic          busy_at_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin : dump_monitor
        dump_exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("dump_hold_valid", 32'(dump_valid), 32'd1);
                check("dump_hold_addr", 32'(dump_addr), 32'(prev_addr));
                check("dump_hold_data", 32'(dump_data), 32'(prev_data));
            end
            if (dump_valid && dump_ready) begin
                hs_count++;
                if (dump_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dump_extra: got word at addr 0x%0h, expected none", dump_addr);
                end else begin
                    e = dump_q.pop_front();
                    check("dump_addr", 32'(dump_addr), 32'(e.a));
                    check("dump_data", 32'(dump_data), 32'(e.d));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_addr  = dump_addr;
            prev_data  = dump_data;
            if (sweep_done) begin
                done_count++;
                done_cyc     = cyc;
                busy_at_done = mem_busy;
            end
        end
    end

    // Consumer backpressure: dump_ready flips every 3 cycles when enabled.
    logic bp_en  = 1'b0;
    int   bp_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                bp_cnt = 0;
                dump_ready = !dump_ready;
            end
        end else begin
            dump_ready = 1'b1;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic pipe(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] m, input logic [DW-1:0] exp, input logic chk_s,
                        input logic [DW-1:0] exp_s);
        rd_exp_t e;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; mem_addr = a; mem_write_data = d; lane_mask = m; rd_issue = rd;
        if (rd) begin
            e.exp = exp; e.chk_small = chk_s; e.exp_small = exp_s;
            rd_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; rd_issue = 1'b0; lane_mask = 2'b00;
    endtask

    task automatic start_sweep(input logic mode);
        @(posedge clk); #1;
        sweep_start = 1'b1; sweep_mode = mode; start_cyc = cyc;
        @(posedge clk); #1;
        sweep_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic chk_lat, input int exp_lat);
        int base = done_count;
        int n = 0;
        while (done_count == base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_count == base) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no sweep_done in %0d cycles, expected one", name, n);
        end else begin
            if (chk_lat) check({name, "_latency"}, 32'(done_cyc - start_cyc), 32'(exp_lat));
            check({name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
            repeat (3) @(posedge clk);
            check({name, "_done_pulses"}, 32'(done_count - base), 32'd1);
            check({name, "_busy_after"}, 32'(mem_busy), 32'd0);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) pipe(1'b0, 1'b1, AW'(i), DW'(i), 2'b11, '0, 1'b0, '0);
        idle();
    endtask

    task automatic push_dump_all();
        dump_exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.a = AW'(i); e.d = DW'(i);
            dump_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_base, done_base, n;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", 32'(mem_read_data), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_addr", 32'(dump_addr), 32'd0);
        check("rst_dump_data", 32'(dump_data), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        rst = 1'b0;

        // Lane-masked writes.
        pipe(1'b0, 1'b1, 8'd5, 20'hABCDE, 2'b11, '0, 1'b0, '0);
        pipe(1'b0, 1'b1, 8'd5, 20'h00012, 2'b01, '0, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd5, '0, 2'b00, 20'hABC12, 1'b1, 20'hABC12);
        pipe(1'b0, 1'b1, 8'd5, 20'h55555, 2'b10, '0, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd5, '0, 2'b00, 20'h55412, 1'b0, '0);
        pipe(1'b0, 1'b1, 8'd5, 20'hFFFFF, 2'b00, '0, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd5, '0, 2'b00, 20'h55412, 1'b0, '0);

        // Read-before-write on the same address.
        pipe(1'b0, 1'b1, 8'd7, 20'h11111, 2'b11, '0, 1'b0, '0);
        pipe(1'b1, 1'b1, 8'd7, 20'h22222, 2'b11, 20'h11111, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd7, '0, 2'b00, 20'h22222, 1'b0, '0);
        idle();
        idle();
        @(negedge clk);
        check("rd_hold_idle", 32'(mem_read_data), 32'h22222);

        // Out of range on the 200-word instance; boundary word 199 in range.
        pipe(1'b0, 1'b1, 8'd220, 20'h12345, 2'b11, '0, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd220, '0, 2'b00, 20'h12345, 1'b1, 20'h00000);
        pipe(1'b0, 1'b1, 8'd199, 20'h0ABCD, 2'b11, '0, 1'b0, '0);
        pipe(1'b1, 1'b0, 8'd199, '0, 2'b00, 20'h0ABCD, 1'b1, 20'h0ABCD);
        idle();

        // Dump with backpressure; a mid-sweep clear request must be ignored.
        preload();
        bp_en = 1'b1;
        push_dump_all();
        hs_base = hs_count;
        start_sweep(SWEEP_DUMP);
        n = 0;
        while ((hs_count - hs_base) < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        sweep_start = 1'b1; sweep_mode = SWEEP_CLEAR;
        @(posedge clk); #1;
        sweep_start = 1'b0; sweep_mode = SWEEP_DUMP;
        wait_done("dump_bp", 1'b0, 0);
        check("dump_bp_handshakes", 32'(hs_count - hs_base), 32'd256);
        check("dump_bp_leftover", 32'(dump_q.size()), 32'd0);
        bp_en = 1'b0;

        // Clear with a gated pipeline store at cycle 10.
        pipe(1'b1, 1'b0, 8'd9, '0, 2'b00, 20'd9, 1'b0, '0);
        idle();
        start_sweep(SWEEP_CLEAR);
        repeat (9) @(posedge clk);
        #1;
        check("clr_busy", 32'(mem_busy), 32'd1);
        MemWrite = 1'b1; MemRead = 1'b1; mem_addr = 8'd3; mem_write_data = 20'h3FFFF; lane_mask = 2'b11;
        @(posedge clk); #1;
        MemWrite = 1'b0; MemRead = 1'b0; lane_mask = 2'b00;
        @(negedge clk);
        check("rd_hold_busy", 32'(mem_read_data), 32'(last_rd_exp));
        wait_done("clear", 1'b1, 258);
        for (int i = 0; i < 256; i++) pipe(1'b1, 1'b0, AW'(i), '0, 2'b00, 20'd0, 1'b0, '0);
        idle();
        idle();

        // Reset in the middle of a dump, then a clean dump from address 0.
        preload();
        push_dump_all();
        hs_base = hs_count;
        start_sweep(SWEEP_DUMP);
        n = 0;
        while ((hs_count - hs_base) < 40 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        check("rstmid_handshakes", 32'(hs_count - hs_base), 32'd40);
        @(posedge clk); #2;
        check("rstmid_valid_before", 32'(dump_valid), 32'd1);
        check("rstmid_addr_before", 32'(dump_addr), 32'd40);
        done_base = done_count;
        rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(dump_valid), 32'd0);
        check("rstmid_busy", 32'(mem_busy), 32'd0);
        check("rstmid_addr", 32'(dump_addr), 32'd0);
        dump_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        check("rstmid_no_done", 32'(done_count - done_base), 32'd0);
        push_dump_all();
        hs_base = hs_count;
        start_sweep(SWEEP_DUMP);
        wait_done("dump_after_rst", 1'b1, 514);
        check("dump_after_rst_handshakes", 32'(hs_count - hs_base), 32'd256);
        check("dump_after_rst_leftover", 32'(dump_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
